// File: rtl/mic_pdm_out_pkg.sv
// Shared widths, sample types and the modulator offset for the mic-to-PDM path.
`timescale 1ns/1ps
package mic_pkg;
    localparam int FRAME_W = 64;
    localparam int SLOT_W  = 32;

    typedef logic signed [23:0] sample24_t;
    typedef logic signed [15:0] sample16_t;

    // Adding this to a two's-complement sample gives offset binary for the modulator.
    localparam logic [15:0] PDM_OFFSET = 16'h8000;
endpackage

// File: rtl/mic_pdm_out_if.sv
// Frame input, control and audio output bundle between the I2S receiver side and mic_pdm_out.
`timescale 1ns/1ps
interface mic_pdm_out_if;
    import mic_pkg::*;

    logic [FRAME_W-1:0] frame_in;
    logic               frame_valid_in;
    logic               ch_sel_in;
    logic [3:0]         shift_in;
    logic               mute_in;
    sample16_t          sample_out;
    logic               sample_valid_out;
    logic               stale_out;
    logic               pdm_out;

    modport master (
        output frame_in, frame_valid_in, ch_sel_in, shift_in, mute_in,
        input  sample_out, sample_valid_out, stale_out, pdm_out
    );

    modport slave (
        input  frame_in, frame_valid_in, ch_sel_in, shift_in, mute_in,
        output sample_out, sample_valid_out, stale_out, pdm_out
    );
endinterface

// File: rtl/mic_pdm_out_sigma_delta.sv
// First-order sigma-delta modulator: every MOD_DIV clocks adds the offset-binary sample
// into a 16-bit accumulator and emits the carry as the PDM bit.
`timescale 1ns/1ps
module sigma_delta_mod
    import mic_pkg::*;
#(
    parameter int MOD_DIV = 4
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  sample16_t sample,
    input  logic      mute,
    output logic      pdm
);
    localparam int CNT_W = (MOD_DIV > 1) ? $clog2(MOD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOD_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [15:0]      acc;
    logic [15:0]      u;
    logic [16:0]      sum;

    assign tick = (cnt == CNT_LAST);

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        u   = mute ? PDM_OFFSET : (sample + PDM_OFFSET);
        sum = {1'b0, acc} + {1'b0, u};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt <= '0;
            acc <= '0;
            pdm <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                acc <= sum[15:0];
                pdm <= sum[16];
            end
        end
    end
endmodule

// File: rtl/mic_pdm_out.sv
// Selects a slot from each I2S frame, applies power-of-two gain with 16-bit saturation,
// tracks frame staleness and drives the sigma-delta speaker bitstream.
`timescale 1ns/1ps
module mic_pdm_out
    import mic_pkg::*;
#(
    parameter int SAMPLE_W     = 24,
    parameter int OUT_W        = 16,
    parameter int SLOT_MSB     = 30,
    parameter int MOD_DIV      = 4,
    parameter int STALE_CYCLES = 4096
) (
    input  logic          clk_in,
    input  logic          rst_in,
    mic_pdm_out_if.slave  bus
);
    localparam int WIDE_W  = SAMPLE_W + 15;
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);
    localparam logic [STALE_W-1:0] STALE_MAX  = STALE_W'(STALE_CYCLES);
    localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_CYCLES - 1);
    localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [WIDE_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [SLOT_W-1:0]          slot;
    logic                       unused_slot_bits;
    logic signed [SAMPLE_W-1:0] s1;
    logic [3:0]                 shift1;
    logic                       v1;
    logic signed [WIDE_W-1:0]   wide;
    logic signed [WIDE_W-1:0]   r;
    logic [OUT_W-1:0]           sat;
    logic [STALE_W-1:0]         stale_cnt;
    sample16_t                  sample_q;
    logic                       valid_q;
    logic                       stale_q;

    assign slot = bus.ch_sel_in ? bus.frame_in[SLOT_W-1:0] : bus.frame_in[FRAME_W-1:SLOT_W];
    // The I2S delay bit and the padding below the sample carry no audio.
    assign unused_slot_bits = ^{slot[SLOT_W-1:SLOT_MSB+1], slot[SLOT_MSB-SAMPLE_W:0]};

    // NOTE: state registers use non-blocking assignments so every stage sees pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1     <= '0;
            shift1 <= '0;
            v1     <= 1'b0;
        end else begin
            v1 <= bus.frame_valid_in;
            if (bus.frame_valid_in) begin
                s1     <= slot[SLOT_MSB -: SAMPLE_W];
                shift1 <= bus.shift_in;
            end
        end
    end

    always_comb begin
        wide = $signed({{(WIDE_W - SAMPLE_W){s1[SAMPLE_W-1]}}, s1}) <<< shift1;
        r    = wide >>> (SAMPLE_W - OUT_W);
        sat  = r[OUT_W-1:0];
        if (r > SAT_MAX) begin
            sat = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (r < SAT_MIN) begin
            sat = {1'b1, {(OUT_W - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sample_q  <= '0;
            valid_q   <= 1'b0;
            stale_q   <= 1'b1;
            stale_cnt <= STALE_MAX;
        end else begin
            valid_q <= v1;
            if (bus.frame_valid_in) begin
                stale_cnt <= '0;
            end else if (stale_cnt != STALE_MAX) begin
                stale_cnt <= stale_cnt + 1'b1;
            end

            // A fresh sample always wins; otherwise the held sample is zeroed once silence saturates.
            if (v1) begin
                sample_q <= sat;
                stale_q  <= 1'b0;
            end else if (!bus.frame_valid_in && stale_cnt == STALE_LAST) begin
                sample_q <= '0;
                stale_q  <= 1'b1;
            end
        end
    end

    assign bus.sample_out       = sample_q;
    assign bus.sample_valid_out = valid_q;
    assign bus.stale_out        = stale_q;

    sigma_delta_mod #(
        .MOD_DIV (MOD_DIV)
    ) u_mod (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .sample (sample_q),
        .mute   (bus.mute_in),
        .pdm    (bus.pdm_out)
    );
endmodule
